// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one core request at a time, performs the
// word/byte access on the accept edge and presents the response after LATENCY_P cycles.
module dmem_responder #(
    parameter int DATA_ADDR_W = 12,
    parameter int LATENCY_P   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [35:0]            mem_i,
    input  logic [DATA_ADDR_W+1:0] addr_i,
    output logic [33:0]            mem_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int         WORDS    = 1 << DATA_ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY_P - 1);

    // Little-endian lane extraction, zero-extended (LBU).
    function automatic logic [31:0] extract_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [31:0] res;
        case (lane)
            2'd0:    res = {24'd0, word[7:0]};
            2'd1:    res = {24'd0, word[15:8]};
            2'd2:    res = {24'd0, word[23:16]};
            2'd3:    res = {24'd0, word[31:24]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Replace one lane of a word, leaving the other lanes untouched (SB).
    function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [7:0] data);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            2'd3:    res[31:24] = data;
            default: res       = word;
        endcase
        return res;
    endfunction

    logic [31:0]            wdata_s;
    logic                   req_valid_s;
    logic                   req_wen_s;
    logic                   req_bnw_s;
    logic                   core_yumi_s;
    logic [DATA_ADDR_W-1:0] word_idx_s;
    logic [1:0]             lane_s;
    logic [31:0]            word_rd_s;
    logic [31:0]            rsp_data_s;
    logic                   accept_s;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [0:WORDS-1];

    assign wdata_s     = mem_i[35:4];
    assign req_valid_s = mem_i[3];
    assign req_wen_s   = mem_i[2];
    assign req_bnw_s   = mem_i[1];
    assign core_yumi_s = mem_i[0];
    assign word_idx_s  = addr_i[DATA_ADDR_W+1:2];
    assign lane_s      = addr_i[1:0];
    assign word_rd_s   = mem_q[word_idx_s];

    assign mem_o = {rdata_q, valid_q, accept_s};

    // Response payload: writes answer with zero, reads with the word or the selected lane.
    always_comb begin
        rsp_data_s = 32'd0;
        if (req_wen_s) begin
            rsp_data_s = 32'd0;
        end else if (req_bnw_s) begin
            rsp_data_s = extract_byte(word_rd_s, lane_s);
        end else begin
            rsp_data_s = word_rd_s;
        end
    end

    // Handshake FSM: next state, latency counter and accept strobe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept_s = req_valid_s & ~reset;
                if (accept_s) begin
                    cnt_d = CNT_LOAD;
                    if (LATENCY_P > 1) begin
                        state_d = ST_BUSY;
                        valid_d = 1'b0;
                    end else begin
                        state_d = ST_RESP;
                        valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_BUSY;
                    valid_d = 1'b0;
                end
            end
            ST_RESP: begin
                // The consume cycle never accepts; the next request waits for IDLE.
                if (core_yumi_s) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            if (accept_s) begin
                rdata_q <= rsp_data_s;
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    // Storage array: written on the accept edge, never cleared by reset.
    always_ff @(posedge clk) begin
        if (accept_s && req_wen_s) begin
            if (req_bnw_s) begin
                mem_q[word_idx_s] <= merge_byte(word_rd_s, lane_s, wdata_s[7:0]);
            end else begin
                mem_q[word_idx_s] <= wdata_s;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder (LATENCY_P=2 main instance,
// plus a LATENCY_P=1 instance for the minimum-latency handshake).
module tb_dmem_responder;

    localparam int AW  = 12;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] wd0, wd1;
    logic        v0, w0, b0, y0, v1, w1, b1, y1;
    logic [13:0] a0, a1;
    logic [33:0] mo0, mo1;

    dmem_responder #(.DATA_ADDR_W(AW), .LATENCY_P(LAT)) dut0 (
        .clk(clk), .reset(reset), .mem_i({wd0, v0, w0, b0, y0}), .addr_i(a0), .mem_o(mo0));
    dmem_responder #(.DATA_ADDR_W(AW), .LATENCY_P(1)) dut1 (
        .clk(clk), .reset(reset), .mem_i({wd1, v1, w1, b1, y1}), .addr_i(a1), .mem_o(mo1));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] ref_mem [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference behaviour: word-indexed array, byte lanes by shifting.
    function automatic logic [31:0] model(input logic wen, input logic bnw,
                                          input logic [13:0] addr, input logic [31:0] wdata);
        int          idx;
        int          sh;
        logic [31:0] word;
        idx  = int'(addr) / 4;
        sh   = 8 * (int'(addr) % 4);
        word = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
        if (wen) begin
            if (bnw) ref_mem[idx] = (word & ~(32'hFF << sh)) | ({24'd0, wdata[7:0]} << sh);
            else     ref_mem[idx] = wdata;
            return 32'd0;
        end
        if (bnw) return (word >> sh) & 32'hFF;
        return word;
    endfunction

    // Drive a request until accepted; optionally enqueue the expected response.
    task automatic issue(input logic wen, input logic bnw, input logic [13:0] addr,
                         input logic [31:0] wdata, input bit expect_rsp, output int waits);
        bit got;
        logic [31:0] d;
        @(negedge clk);
        v0 = 1'b1; w0 = wen; b0 = bnw; a0 = addr; wd0 = wdata;
        got = 1'b0;
        waits = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (mo0[0]) got = 1'b1;
            else begin waits++; @(negedge clk); end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        else begin
            d = model(wen, bnw, addr, wdata);
            if (expect_rsp) sbq.push_back('{d, cyc + LAT});
        end
        @(negedge clk);
        v0 = 1'b0;
    endtask

    task automatic consume(input int hold);
        for (int i = 0; i < 40 && !mo0[1]; i++) @(negedge clk);
        chk("valid_seen", {31'd0, mo0[1]}, 32'd1);
        repeat (hold) @(negedge clk);
        chk("valid_held", {31'd0, mo0[1]}, 32'd1);
        y0 = 1'b1;
        @(negedge clk);
        y0 = 1'b0;
        chk("valid_clear", {31'd0, mo0[1]}, 32'd0);
    endtask

    // Monitor: checks latency on each rising valid and data on every valid cycle.
    initial begin
        exp_t cur;
        logic prev;
        cur  = '{32'd0, 0};
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (mo0[1]) begin
                if (!prev) begin
                    if (sbq.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
                    else begin
                        cur = sbq.pop_front();
                        chk("rsp_latency", 32'(cyc), 32'(cur.cyc));
                    end
                end
                chk("rsp_data", mo0[33:2], cur.data);
            end
            prev = mo0[1];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          w;
        int          k1;
        int          cons_cyc;
        int          base;
        int          idx;
        logic [15:0] wide_addr;
        logic [13:0] ad;
        logic [31:0] d;

        reset = 1'b1;
        {v0, w0, b0, y0, a0, wd0} = '0;
        {v1, w1, b1, y1, a1, wd1} = '0;
        repeat (3) @(negedge clk);
        v0 = 1'b1;
        #1;
        chk("reset_yumi", {31'd0, mo0[0]}, 32'd0);
        chk("reset_valid", {31'd0, mo0[1]}, 32'd0);
        chk("reset_rdata", mo0[33:2], 32'd0);
        @(negedge clk);
        v0 = 1'b0;
        reset = 1'b0;

        // SW then LW with a held response.
        issue(1'b1, 1'b0, 14'h0010, 32'hDEADBEEF, 1'b1, w); consume(0);
        issue(1'b0, 1'b0, 14'h0010, 32'd0, 1'b1, w);
        chk("yumi_immediate", 32'(w), 32'd0);
        consume(3);

        // Byte store into an existing word, then word and byte loads.
        issue(1'b1, 1'b0, 14'h0010, 32'h11223344, 1'b1, w); consume(0);
        issue(1'b1, 1'b1, 14'h0011, 32'h000000AA, 1'b1, w); consume(1);
        chk("sb_model_word", ref_mem[4], 32'h1122AA44);
        issue(1'b0, 1'b0, 14'h0010, 32'd0, 1'b1, w); consume(0);
        issue(1'b0, 1'b1, 14'h0013, 32'd0, 1'b1, w); consume(0);
        issue(1'b0, 1'b1, 14'h0011, 32'd0, 1'b1, w); consume(2);

        // Second request held while the first response is unconsumed.
        issue(1'b0, 1'b0, 14'h0010, 32'd0, 1'b1, w);
        for (int i = 0; i < 40 && !mo0[1]; i++) @(negedge clk);
        v0 = 1'b1; w0 = 1'b0; b0 = 1'b1; a0 = 14'h0013;
        repeat (2) begin
            #1;
            chk("held_no_yumi", {31'd0, mo0[0]}, 32'd0);
            @(negedge clk);
        end
        y0 = 1'b1;
        #1;
        chk("no_accept_on_consume", {31'd0, mo0[0]}, 32'd0);
        cons_cyc = cyc;
        @(negedge clk);
        y0 = 1'b0;
        #1;
        chk("accept_after_consume", {31'd0, mo0[0]}, 32'd1);
        chk("accept_cycle", 32'(cyc - cons_cyc), 32'd1);
        sbq.push_back('{model(1'b0, 1'b1, 14'h0013, 32'd0), cyc + LAT});
        @(negedge clk);
        v0 = 1'b0;
        consume(1);

        // Address wrap: bit 14 falls off the port.
        wide_addr = 16'h4000;
        issue(1'b1, 1'b0, wide_addr[13:0], 32'h00000005, 1'b1, w); consume(0);
        issue(1'b0, 1'b0, 14'h0000, 32'd0, 1'b1, w); consume(0);
        chk("wrap_model", ref_mem[0], 32'h00000005);

        // Reset during BUSY drops the read; prior write persists.
        issue(1'b1, 1'b0, 14'h0040, 32'h0BADF00D, 1'b1, w); consume(0);
        issue(1'b0, 1'b0, 14'h0040, 32'd0, 1'b0, w);
        reset = 1'b1;
        v0 = 1'b1;
        #1;
        chk("yumi_in_reset", {31'd0, mo0[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        v0 = 1'b0;
        repeat (3) begin
            chk("dropped_no_valid", {31'd0, mo0[1]}, 32'd0);
            @(negedge clk);
        end
        issue(1'b0, 1'b0, 14'h0040, 32'd0, 1'b1, w);
        chk("post_reset_accept", 32'(w), 32'd0);
        consume(0);

        // Randomized traffic over a small pool of words.
        base = int'($urandom_range(0, 4087));
        for (int i = 0; i < 8; i++) begin
            ad = 14'((base + i) * 4);
            issue(1'b1, 1'b0, ad, $urandom, 1'b1, w);
            consume(0);
        end
        for (int i = 0; i < 80; i++) begin
            idx = base + int'($urandom_range(0, 7));
            ad  = 14'(idx * 4 + int'($urandom_range(0, 3)));
            d   = $urandom;
            issue(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), ad, d, 1'b1, w);
            consume(int'($urandom_range(0, 3)));
        end

        // LATENCY_P=1 instance: next-cycle valid and 3-cycle request period.
        @(negedge clk);
        v1 = 1'b1; w1 = 1'b1; b1 = 1'b0; a1 = 14'h0020; wd1 = 32'hCAFEF00D;
        #1;
        chk("l1_sw_yumi", {31'd0, mo1[0]}, 32'd1);
        @(negedge clk);
        v1 = 1'b0;
        chk("l1_sw_valid", {31'd0, mo1[1]}, 32'd1);
        chk("l1_sw_data", mo1[33:2], 32'd0);
        y1 = 1'b1;
        @(negedge clk);
        y1 = 1'b0;
        chk("l1_sw_clear", {31'd0, mo1[1]}, 32'd0);
        v1 = 1'b1; w1 = 1'b0;
        #1;
        chk("l1_lw_yumi", {31'd0, mo1[0]}, 32'd1);
        k1 = cyc;
        @(negedge clk);
        v1 = 1'b0;
        chk("l1_lw_valid", {31'd0, mo1[1]}, 32'd1);
        chk("l1_lw_data", mo1[33:2], 32'hCAFEF00D);
        @(negedge clk);
        chk("l1_lw_hold", {31'd0, mo1[1]}, 32'd1);
        y1 = 1'b1; v1 = 1'b1;
        #1;
        chk("l1_no_acc_consume", {31'd0, mo1[0]}, 32'd0);
        @(negedge clk);
        y1 = 1'b0;
        #1;
        chk("l1_acc_next", {31'd0, mo1[0]}, 32'd1);
        chk("l1_period", 32'(cyc - k1), 32'd3);
        @(negedge clk);
        v1 = 1'b0;
        chk("l1_lw2_valid", {31'd0, mo1[1]}, 32'd1);
        chk("l1_lw2_data", mo1[33:2], 32'hCAFEF00D);
        y1 = 1'b1;
        @(negedge clk);
        y1 = 1'b0;
        chk("l1_lw2_clear", {31'd0, mo1[1]}, 32'd0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the core-to-data-memory handshake.
- Consumes the core's `mem_in_s` request plus a byte address, and produces the `mem_out_s` acknowledge and response.
- Holds 2^`DATA_ADDR_W` 32-bit words with a programmable response latency.
- Sits beside the core in the tile and serves LW/LBU/SW/SB with one request outstanding.

Parameters:
- `DATA_ADDR_W`, 12 (= `data_mem_addr_width_gp`), log2 of the number of 32-bit words.
- `LATENCY_P`, 2, cycles from the accept cycle to the first cycle of `valid`; legal range 1..15.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `mem_i`  in  `$bits(mem_in_s)` = 36  — `{write_data, valid, wen, byte_not_word, yumi}` from the core.
- `addr_i`  in  `DATA_ADDR_W`+2 = 14  — byte address, sampled only in the accept cycle.
- `mem_o`  out  `$bits(mem_out_s)` = 34  — `{read_data, valid, yumi}` to the core.

Behaviour:
- Reset state:
  - State goes to IDLE.
  - `mem_o.valid`=0, `mem_o.read_data`=0, latency counter=0.
  - `mem_o.yumi`=0 while `reset`=1.
  - Storage array is not cleared.
- Clock and reset are single-clock, synchronous, active-high.
- States: IDLE, BUSY, RESP.
- IDLE:
  - `mem_o.yumi` = `mem_i.valid` & ~`reset` (combinational, the accept cycle).
  - On accept: latch `wen`, `byte_not_word`, `addr_i`, `write_data`; load counter with `LATENCY_P`-1.
  - Next state: BUSY if `LATENCY_P`>1, else RESP.
- BUSY:
  - `mem_o.yumi`=0; decrement counter.
  - When counter==1 at the clock edge, go to RESP.
  - Net effect: `valid` is first high exactly `LATENCY_P` cycles after the accept cycle.
- RESP:
  - `mem_o.valid`=1; `read_data` is held stable.
  - When `mem_i.yumi`=1: clear `valid` and go to IDLE at the edge.
  - A new request cannot be accepted in the same cycle as the consume; the earliest accept is the next cycle.
- Requests during BUSY/RESP: not accepted, `mem_o.yumi`=0. The core must hold `valid` and its fields until it sees `yumi`.
- `mem_i.yumi` outside RESP is ignored.
- Addressing:
  - Word index = `addr[DATA_ADDR_W+1:2]`; byte lane = `addr[1:0]`, little-endian (lane 0 = bits 7:0).
  - Word ops ignore `addr[1:0]`.
  - All addresses wrap modulo the array size; no error is raised.
- Writes:
  - Commit to the array at the edge ending the accept cycle.
  - Word write (`wen`=1, `byte_not_word`=0): full 32 bits.
  - Byte write: `write_data[7:0]` into the selected lane; other lanes unchanged.
  - Response still issued (same latency and handshake) with `read_data`=0.
- Reads:
  - Array read at the edge ending the accept cycle; result held in the response register.
  - Word read returns the full word.
  - Byte read (LBU) returns the selected lane, zero-extended to 32 bits.
- Ordering: one outstanding request, so a read after a write always sees the written data.
- `reset` mid-operation:
  - Any BUSY/RESP transaction is dropped; no `valid` is issued for it.
  - A write already accepted stays committed.
  - State returns to IDLE the next cycle.
- `read_data` changes only on response load or reset; it is not required to be zero outside RESP.

Test Plan:
- Reset, then SW of 0xDEADBEEF to `addr` 0x0010, then LW from 0x0010 with `LATENCY_P`=2:
  - `yumi` high in the accept cycle.
  - `valid` high exactly 2 cycles later with `read_data`=0xDEADBEEF.
  - `valid` holds 3 extra cycles while `mem_i.yumi`=0, then clears the cycle after `mem_i.yumi`.
- SB 0xAA to 0x0011 over word 0x11223344 at 0x0010:
  - LW 0x0010 returns 0x1122AA44.
  - LBU 0x0013 returns 0x00000011.
  - LBU 0x0011 returns 0x000000AA.
- Request held during RESP: second LW asserted while the first response is unconsumed:
  - `mem_o.yumi`=0 until the cycle after the consume.
  - Second response returns the correct data.
- Address wrap: SW 0x5 to 0x4000 (bit 14 beyond width, truncated) → LW 0x0000 returns 0x00000005.
- `reset` asserted during BUSY of an LW:
  - `valid` never rises for it.
  - Next LW accepted normally.
  - A prior SW's data persists.
- `LATENCY_P`=1 build:
  - `valid` rises the cycle after accept.
  - Back-to-back LW/consume/LW sequence gives a minimum 3-cycle request period.
